// File: rtl/neander_mem_pkg.sv
// Shared types and default widths for the Neander program/data memory.
package neander_mem_pkg;

  localparam int NEANDER_DATA_W = 8;
  localparam int NEANDER_ADDR_W = 8;

  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} ld_state_t;

endpackage

// File: rtl/neander_mem_loader.sv
// Streaming program loader: owns the memory write port while a load is in flight.
// Optional running checksum of loaded words when NEANDER_LOAD_CSUM_EN is defined.
module neander_mem_loader
  import neander_mem_pkg::*;
#(
  parameter int DATA_W = NEANDER_DATA_W,
  parameter int ADDR_W = NEANDER_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
`ifdef NEANDER_LOAD_CSUM_EN
  output logic [DATA_W-1:0] ld_csum,
`endif
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
`ifdef NEANDER_LOAD_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef NEANDER_LOAD_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      LD_IDLE: begin
        if (ld_start) begin
          if (ld_len > DEPTH_L) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
`ifdef NEANDER_LOAD_CSUM_EN
            csum_d = '0;
`endif
            if (ld_len == '0) begin
              state_d = LD_DONE;
            end else begin
              ptr_d   = ld_base;
              cnt_d   = ld_len;
              state_d = LD_LOAD;
            end
          end
        end
      end
      LD_LOAD: begin
        if (ld_start) err_d = 1'b1;
        if (ld_valid) begin
          // Pointer wraps naturally at DEPTH-1 through its ADDR_W width.
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
`ifdef NEANDER_LOAD_CSUM_EN
          csum_d = csum_q + ld_data;
`endif
          if (cnt_q == {{ADDR_W{1'b0}}, 1'b1}) state_d = LD_DONE;
        end
      end
      LD_DONE: begin
        if (ld_start) err_d = 1'b1;
        state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LD_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef NEANDER_LOAD_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef NEANDER_LOAD_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Handshake outputs come straight off the state register.
  assign ld_ready = (state_q == LD_LOAD);
  assign ld_done  = (state_q == LD_DONE);
  assign hold     = (state_q != LD_IDLE);
  assign ld_err   = err_q;
  assign wr_en    = ld_ready & ld_valid;
  assign wr_addr  = ptr_q;
  assign wr_data  = ld_data;
`ifdef NEANDER_LOAD_CSUM_EN
  assign ld_csum  = csum_q;
`endif

endmodule

// File: rtl/neander_prog_mem.sv
// Neander program/data RAM with CPU port, streaming loader and registered readback.
// Define NEANDER_LOAD_CSUM_EN to add the ld_csum load-checksum output.
module neander_prog_mem
  import neander_mem_pkg::*;
#(
  parameter int DATA_W = NEANDER_DATA_W,
  parameter int ADDR_W = NEANDER_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  input  logic              rb_req,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic              rb_valid,
`ifdef NEANDER_LOAD_CSUM_EN
  output logic [DATA_W-1:0] ld_csum,
`endif
  output logic [DATA_W-1:0] rb_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_data;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              rb_valid_q, rb_valid_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;

  neander_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_loader (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .hold     (cpu_hold),
    .wr_en    (ldr_we),
    .wr_addr  (ldr_addr),
`ifdef NEANDER_LOAD_CSUM_EN
    .ld_csum  (ld_csum),
`endif
    .wr_data  (ldr_data)
  );

  // Loader wins the write port; CPU writes are dropped while it holds the CPU.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = cpu_addr;
    mem_wdata_d = cpu_wdata;
    if (ldr_we) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = ldr_addr;
      mem_wdata_d = ldr_data;
    end else if (cpu_we && !cpu_hold) begin
      mem_we_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[mem_addr_d] <= mem_wdata_d;
  end

  assign cpu_rdata = mem_q[cpu_addr];

  // Readback samples the pre-write contents on a same-edge write.
  always_comb begin
    rb_valid_d = rb_req;
    rb_data_d  = rb_req ? mem_q[rb_addr] : rb_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end else begin
      rb_valid_q <= rb_valid_d;
      rb_data_q  <= rb_data_d;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;

endmodule

// File: tb/tb_neander_prog_mem.sv
// Bench for neander_prog_mem: directed scenarios plus randomized traffic against a behavioural model.
module tb_neander_prog_mem;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_we = 1'b0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_hold;
  logic          ld_start = 1'b0;
  logic [AW-1:0] ld_base = '0;
  logic [AW:0]   ld_len = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          ld_done;
  logic          ld_err;
  logic          rb_req = 1'b0;
  logic [AW-1:0] rb_addr = '0;
  logic          rb_valid;
  logic [DW-1:0] rb_data;
`ifdef NEANDER_LOAD_CSUM_EN
  logic [DW-1:0] ld_csum;
`endif

  always #5 clk = ~clk;

  neander_prog_mem dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_hold  (cpu_hold),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_len    (ld_len),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .ld_err    (ld_err),
    .rb_req    (rb_req),
    .rb_addr   (rb_addr),
    .rb_valid  (rb_valid),
`ifdef NEANDER_LOAD_CSUM_EN
    .ld_csum   (ld_csum),
`endif
    .rb_data   (rb_data)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image with known-bits, load progress as a word count.
  logic [DW-1:0] mem_m [DEPTH];
  bit            known_m [DEPTH];
  bit            m_loading = 0, m_done = 0, m_err = 0, m_rbv = 0, m_rbk = 1;
  logic [DW-1:0] m_rbd = '0, m_csum = '0;
  int            m_ptr = 0, m_rem = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_loading = 0; m_done = 0; m_err = 0;
      m_rbv = 0; m_rbd = '0; m_rbk = 1; m_csum = '0;
    end else begin
      bit idle, was_done;
      idle = !m_loading && !m_done;
      was_done = m_done;
      if (rb_req) begin
        m_rbv = 1; m_rbd = mem_m[rb_addr]; m_rbk = known_m[rb_addr];
      end else begin
        m_rbv = 0;
      end
      if (m_loading && ld_valid) begin
        mem_m[m_ptr] = ld_data;
        known_m[m_ptr] = 1;
        m_csum = m_csum + ld_data;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_rem--;
        if (m_rem == 0) begin m_loading = 0; m_done = 1; end
      end else if (cpu_we && idle) begin
        mem_m[cpu_addr] = cpu_wdata;
        known_m[cpu_addr] = 1;
      end
      if (was_done) m_done = 0;
      if (ld_start) begin
        if (!idle || int'(ld_len) > DEPTH) m_err = 1;
        else begin
          m_err = 0;
          m_csum = '0;
          if (ld_len == 0) m_done = 1;
          else begin m_loading = 1; m_ptr = int'(ld_base); m_rem = int'(ld_len); end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cpu_hold", cpu_hold, m_loading || m_done);
    chk("ld_ready", ld_ready, m_loading);
    chk("ld_done", ld_done, m_done);
    chk("ld_err", ld_err, m_err);
    chk("rb_valid", rb_valid, m_rbv);
    if (m_rbk) chk("rb_data", rb_data, m_rbd);
    if (known_m[cpu_addr]) chk("cpu_rdata", cpu_rdata, mem_m[cpu_addr]);
`ifdef NEANDER_LOAD_CSUM_EN
    chk("ld_csum", ld_csum, m_csum);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    cpu_addr = a;
    tick();
    chk(name, cpu_rdata, exp);
  endtask

  task automatic load(input logic [AW-1:0] base, input logic [DW-1:0] d[$], input bit gaps);
    ld_start = 1'b1; ld_base = base; ld_len = 9'(d.size());
    tick();
    ld_start = 1'b0;
    chk("load_hold_start", cpu_hold, 1);
    for (int i = 0; i < d.size(); i++) begin
      ld_valid = 1'b1; ld_data = d[i];
      tick();
      ld_valid = 1'b0;
      if (gaps && i < d.size() - 1) tick();
    end
    chk("load_done_pulse", ld_done, 1);
    chk("load_hold_done", cpu_hold, 1);
    tick();
    chk("load_done_clear", ld_done, 0);
    chk("load_hold_clear", cpu_hold, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", cpu_hold, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_rb_data", rb_data, 0);
    reset_n = 1'b1;
    tick();

    // Scenario 1: gapped load at 0x10
    load(8'h10, '{8'h20, 8'h30, 8'h40, 8'h50}, 1'b1);
    peek(8'h10, 8'h20, "t1_m10");
    peek(8'h11, 8'h30, "t1_m11");
    peek(8'h12, 8'h40, "t1_m12");
    peek(8'h13, 8'h50, "t1_m13");

    // Scenario 3: CPU write dropped during load, accepted afterwards
    ld_start = 1'b1; ld_base = 8'h60; ld_len = 9'd1;
    tick();
    ld_start = 1'b0;
    cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h99;
    tick();
    cpu_we = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h61;
    tick();
    ld_valid = 1'b0;
    tick();
    peek(8'h10, 8'h20, "t3_dropped");
    cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h99;
    tick();
    cpu_we = 1'b0;
    chk("t3_written", cpu_rdata, 8'h99);

    // Scenario 2: wrap past the top of memory
    load(8'hFE, '{8'hA1, 8'hB2, 8'hC3}, 1'b0);
    peek(8'hFE, 8'hA1, "t2_mFE");
    peek(8'hFF, 8'hB2, "t2_mFF");
    peek(8'h00, 8'hC3, "t2_m00");

    // Scenario 4: zero-length and oversize loads
    ld_start = 1'b1; ld_len = 9'd0;
    tick();
    ld_start = 1'b0;
    chk("t4_len0_done", ld_done, 1);
    tick();
    chk("t4_len0_idle", cpu_hold, 0);
    ld_start = 1'b1; ld_len = 9'd257;
    tick();
    ld_start = 1'b0;
    chk("t4_err", ld_err, 1);
    chk("t4_err_hold", cpu_hold, 0);
    load(8'h70, '{8'h77}, 1'b0);
    chk("t4_err_cleared", ld_err, 0);

    // Scenario 6: readback and checksum
    rb_req = 1'b1; rb_addr = 8'h12;
    tick();
    rb_req = 1'b0;
    rb_addr = 8'h11;
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    chk("t6_rb_valid", rb_valid, 1);
    chk("t6_rb_data", rb_data, 8'h30);
    tick();
    chk("t6_rb_idle", rb_valid, 0);
    chk("t6_rb_hold", rb_data, 8'h30);
    load(8'h80, '{8'hFF, 8'h02}, 1'b0);
`ifdef NEANDER_LOAD_CSUM_EN
    chk("t6_csum", ld_csum, 8'h01);
`endif

    // Scenario 5: reset in the middle of a load
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b1; cpu_addr = 8'(8'h40 + i); cpu_wdata = 8'h00;
      tick();
    end
    cpu_we = 1'b0;
    rb_req = 1'b1; rb_addr = 8'h11;
    ld_start = 1'b1; ld_base = 8'h40; ld_len = 9'd4;
    tick();
    ld_start = 1'b0; rb_req = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hC0;
    tick();
    ld_data = 8'hC1;
    tick();
    ld_data = 8'hC2;
    reset_n = 1'b0;
    #1;
    chk("t5_hold", cpu_hold, 0);
    chk("t5_ready", ld_ready, 0);
    chk("t5_done", ld_done, 0);
    chk("t5_err", ld_err, 0);
    chk("t5_rb_valid", rb_valid, 0);
    chk("t5_rb_data", rb_data, 0);
    ld_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    peek(8'h40, 8'hC0, "t5_m40");
    peek(8'h41, 8'hC1, "t5_m41");
    peek(8'h42, 8'h00, "t5_m42");
    peek(8'h43, 8'h00, "t5_m43");
    load(8'h42, '{8'hD2, 8'hD3}, 1'b0);
    peek(8'h42, 8'hD2, "t5_reload");

    // Randomized traffic checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom % 16);
      ld_start = ($urandom % 20) == 0;
      ld_base  = 8'($urandom % 64);
      if (r == 0)      ld_len = 9'd0;
      else if (r == 1) ld_len = 9'(257 + $urandom % 255);
      else if (r == 2) ld_len = 9'd256;
      else             ld_len = 9'(1 + $urandom % 6);
      ld_valid  = ($urandom % 2) == 0;
      ld_data   = 8'($urandom);
      cpu_we    = ($urandom % 3) == 0;
      cpu_addr  = 8'($urandom % 64);
      cpu_wdata = 8'($urandom);
      rb_req    = ($urandom % 2) == 0;
      rb_addr   = 8'($urandom % 64);
      tick();
    end
    ld_start = 1'b0; ld_valid = 1'b0; cpu_we = 1'b0; rb_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
